// File: rtl/agg_pkg.sv
// Shared definitions for the aggregation engine.
//   - Default lane count and element/accumulator widths.
//   - Default PFT/adjacency address widths and the sample-count width.
//   - FSM state encoding.
//   - Position of the last-neighbour flag in an adjacency entry.
package agg_pkg;

  localparam int unsigned DefLanes    = 16;
  localparam int unsigned DefDataW    = 16;
  localparam int unsigned DefAccW     = 32;
  localparam int unsigned DefPftAddrW = 10;
  localparam int unsigned DefAdjAddrW = 13;
  localparam int unsigned NSampleW    = 13;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAdj  = 3'd1,
    StPft  = 3'd2,
    StAcc  = 3'd3,
    StEmit = 3'd4
  } agg_state_e;

  // An adjacency entry is {last, pft_row}; the flag sits just above the row index.
  function automatic int unsigned adj_last_bit(int unsigned pft_addr_w);
    return pft_addr_w;
  endfunction

endpackage

// File: rtl/agg_sat_add.sv
// Single-lane signed saturating adder.
//   acc_i  : signed ACC_W running sum
//   data_i : signed DATA_W addend, sign-extended to ACC_W
//   sum_o  : acc_i + data_i clamped to the signed ACC_W range
// Requires ACC_W >= DATA_W.
module agg_sat_add
  import agg_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [ACC_W-1:0]  sum_o
);

  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] data_ext;
  logic signed [ACC_W:0] sum_wide;

  // One guard bit is enough: both operands fit in ACC_W signed bits.
  assign acc_ext  = $signed({acc_i[ACC_W-1], acc_i});
  assign data_ext = $signed({{(ACC_W + 1 - DATA_W){data_i[DATA_W-1]}}, data_i});
  assign sum_wide = acc_ext + data_ext;

  always_comb begin
    sum_o = sum_wide[ACC_W-1:0];
    // Guard bit disagreeing with the sign bit means the true sum left the range.
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      if (!sum_wide[ACC_W]) begin
        sum_o = {1'b0, {(ACC_W - 1){1'b1}}};
      end else begin
        sum_o = {1'b1, {(ACC_W - 1){1'b0}}};
      end
    end
  end

endmodule

// File: rtl/aggregation_engine.sv
// Neighbour aggregation engine.
// On an accepted start it walks the adjacency list from address 0; for each sample it
// sums the PFT rows of that sample's neighbours lane by lane with saturation, then
// presents the vector on out_data and pulses aggregation_done for one cycle.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start_aggregation  : start pulse (ignored while busy)
//   N_SAMPLE           : number of samples, latched on accepted start
//   adj_ren/adj_raddr  : adjacency read port, adj_rdata valid one cycle later
//   adj_rdata          : {last flag, neighbour PFT row}
//   pft_ren/pft_raddr  : PFT read port, pft_rdata valid one cycle later
//   pft_rdata          : LANES signed DATA_W elements, lane 0 in LSBs
//   out_data           : accumulator, LANES signed ACC_W lanes
//   aggregation_done   : one pulse per completed sample
//   busy               : engine not idle
module aggregation_engine
  import agg_pkg::*;
#(
  parameter int unsigned LANES      = DefLanes,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned ACC_W      = DefAccW,
  parameter int unsigned PFT_ADDR_W = DefPftAddrW,
  parameter int unsigned ADJ_ADDR_W = DefAdjAddrW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_aggregation,
  input  logic [NSampleW-1:0]       N_SAMPLE,
  output logic                      adj_ren,
  output logic [ADJ_ADDR_W-1:0]     adj_raddr,
  input  logic [PFT_ADDR_W:0]       adj_rdata,
  output logic                      pft_ren,
  output logic [PFT_ADDR_W-1:0]     pft_raddr,
  input  logic [LANES*DATA_W-1:0]   pft_rdata,
  output logic [LANES*ACC_W-1:0]    out_data,
  output logic                      aggregation_done,
  output logic                      busy
);

  localparam int unsigned LastBit = adj_last_bit(PFT_ADDR_W);

  agg_state_e                state_q, state_d;
  logic [LANES*ACC_W-1:0]    acc_q, acc_d;
  logic [LANES*ACC_W-1:0]    acc_sum;
  logic [ADJ_ADDR_W-1:0]     adj_ptr_q, adj_ptr_d;
  logic [NSampleW-1:0]       sample_cnt_q, sample_cnt_d;
  logic [NSampleW-1:0]       n_q, n_d;
  logic                      last_q, last_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    agg_sat_add #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W)
    ) u_sat_add (
      .acc_i (acc_q[i*ACC_W +: ACC_W]),
      .data_i(pft_rdata[i*DATA_W +: DATA_W]),
      .sum_o (acc_sum[i*ACC_W +: ACC_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      adj_ptr_q    <= '0;
      sample_cnt_q <= '0;
      n_q          <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      adj_ptr_q    <= adj_ptr_d;
      sample_cnt_q <= sample_cnt_d;
      n_q          <= n_d;
      last_q       <= last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    adj_ptr_d    = adj_ptr_q;
    sample_cnt_d = sample_cnt_q;
    n_d          = n_q;
    last_d       = last_q;

    unique case (state_q)
      StIdle: begin
        if (start_aggregation) begin
          n_d          = N_SAMPLE;
          adj_ptr_d    = '0;
          sample_cnt_d = '0;
          acc_d        = '0;
          // A zero-sample request is accepted but does no work.
          if (N_SAMPLE != '0) begin
            state_d = StAdj;
          end
        end
      end
      StAdj: begin
        state_d = StPft;
      end
      StPft: begin
        last_d  = adj_rdata[LastBit];
        state_d = StAcc;
      end
      StAcc: begin
        acc_d     = acc_sum;
        adj_ptr_d = adj_ptr_q + ADJ_ADDR_W'(1);
        state_d   = last_q ? StEmit : StAdj;
      end
      StEmit: begin
        acc_d = '0;
        if (sample_cnt_q == n_q - NSampleW'(1)) begin
          sample_cnt_d = '0;
          state_d      = StIdle;
        end else begin
          sample_cnt_d = sample_cnt_q + NSampleW'(1);
          state_d      = StAdj;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs. Addresses are forced to zero outside their read cycle.
  always_comb begin
    adj_ren          = (state_q == StAdj);
    adj_raddr        = (state_q == StAdj) ? adj_ptr_q : '0;
    pft_ren          = (state_q == StPft);
    // Row index passes straight from the adjacency read data to the PFT address.
    pft_raddr        = (state_q == StPft) ? adj_rdata[PFT_ADDR_W-1:0] : '0;
    aggregation_done = (state_q == StEmit);
    busy             = (state_q != StIdle);
    // acc_q is stable through EMIT; it only clears at the end of that cycle.
    out_data         = acc_q;
  end

endmodule

// File: tb/tb_aggregation_engine.sv
module tb_aggregation_engine;

  localparam int LANES  = 16;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 17;
  localparam int PW     = 10;
  localparam int AW     = 13;
  localparam longint AccMax = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint AccMin = -(longint'(1) <<< (ACC_W - 1));

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start_aggregation;
  logic [12:0]             n_sample;
  logic                    adj_ren;
  logic [AW-1:0]           adj_raddr;
  logic [PW:0]             adj_rdata;
  logic                    pft_ren;
  logic [PW-1:0]           pft_raddr;
  logic [LANES*DATA_W-1:0] pft_rdata;
  logic [LANES*ACC_W-1:0]  out_data;
  logic                    aggregation_done;
  logic                    busy;

  always #5 clk = ~clk;

  aggregation_engine #(
    .LANES     (LANES),
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W),
    .PFT_ADDR_W(PW),
    .ADJ_ADDR_W(AW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_aggregation(start_aggregation),
    .N_SAMPLE         (n_sample),
    .adj_ren          (adj_ren),
    .adj_raddr        (adj_raddr),
    .adj_rdata        (adj_rdata),
    .pft_ren          (pft_ren),
    .pft_raddr        (pft_raddr),
    .pft_rdata        (pft_rdata),
    .out_data         (out_data),
    .aggregation_done (aggregation_done),
    .busy             (busy)
  );

  // Memories with one-cycle registered read.
  logic [PW:0]             adj_mem [0:(1<<AW)-1];
  logic [LANES*DATA_W-1:0] pft_mem [0:(1<<PW)-1];

  always @(posedge clk) begin
    if (adj_ren) adj_rdata <= adj_mem[adj_raddr];
    if (pft_ren) pft_rdata <= pft_mem[pft_raddr];
  end

  int     n_chk = 0;
  int     n_fail = 0;
  int     done_cnt = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Job description: neighbour counts per sample and the flat list of neighbour rows.
  int job_k   [0:15];
  int job_row [0:127];

  logic [LANES*ACC_W-1:0] exp_vec_q [$];
  longint                 exp_cyc_q [$];

  function automatic longint clamp(input longint v);
    if (v > AccMax) return AccMax;
    if (v < AccMin) return AccMin;
    return v;
  endfunction

  task automatic load_job(input int n);
    int p = 0;
    for (int s = 0; s < n; s++) begin
      for (int j = 0; j < job_k[s]; j++) begin
        adj_mem[p] = {(j == job_k[s] - 1), PW'(job_row[p])};
        p++;
      end
    end
  endtask

  // Reference: per sample, saturating lane sums over its neighbour rows; each sample
  // takes 3 cycles per neighbour plus one emit cycle, starting the cycle after start.
  task automatic predict(input int n, input longint start_c);
    int     p = 0;
    longint t = start_c;
    longint acc [LANES];
    logic [LANES*ACC_W-1:0] vec;
    logic signed [DATA_W-1:0] dv;
    for (int s = 0; s < n; s++) begin
      for (int l = 0; l < LANES; l++) acc[l] = 0;
      for (int j = 0; j < job_k[s]; j++) begin
        for (int l = 0; l < LANES; l++) begin
          dv = pft_mem[job_row[p]][l*DATA_W +: DATA_W];
          acc[l] = clamp(acc[l] + longint'(dv));
        end
        p++;
      end
      for (int l = 0; l < LANES; l++) vec[l*ACC_W +: ACC_W] = ACC_W'(acc[l]);
      t = t + 3 * job_k[s] + 1;
      exp_vec_q.push_back(vec);
      exp_cyc_q.push_back(t);
    end
  endtask

  // Returns one cycle after the start pulse was driven (start already low).
  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    n_sample = 13'(n);
    start_aggregation = 1'b1;
    predict(n, cyc);
    @(posedge clk); #1;
    start_aggregation = 1'b0;
    n_sample = 13'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_vec_q.size() == 0) break;
    end
    check("drain_pending", exp_vec_q.size(), 0);
    check("idle_busy", busy, 0);
    exp_vec_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic set_row(input int r, input int val);
    for (int l = 0; l < LANES; l++) pft_mem[r][l*DATA_W +: DATA_W] = DATA_W'(val);
  endtask

  // Done monitor: every pulse must match the next predicted sample in time and value.
  always @(negedge clk) begin
    logic [LANES*ACC_W-1:0] ev;
    longint ec;
    logic signed [ACC_W-1:0] g, e;
    if (aggregation_done === 1'b1) begin
      done_cnt++;
      if (exp_vec_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        ev = exp_vec_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("done_cycle", cyc, ec);
        for (int l = 0; l < LANES; l++) begin
          g = out_data[l*ACC_W +: ACC_W];
          e = ev[l*ACC_W +: ACC_W];
          check($sformatf("lane%0d", l), g, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1);
  end

  initial begin
    longint s;
    int     d0, n, p, r, v;

    rst = 1'b1;
    start_aggregation = 1'b0;
    n_sample = '0;
    for (int a = 0; a < (1 << PW); a++) begin
      for (int l = 0; l < LANES; l++) begin
        r = $urandom_range(0, 3);
        v = (r == 0) ? 32767 : (r == 1) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
        pft_mem[a][l*DATA_W +: DATA_W] = DATA_W'(v);
      end
    end

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_ctl", {busy, adj_ren, pft_ren, aggregation_done}, 0);
      check("idle_data", (out_data == '0) && (adj_raddr == '0) && (pft_raddr == '0), 1);
    end

    // Single sample, single neighbour row 5 with lanes 1..16.
    job_k[0] = 1; job_row[0] = 5;
    for (int l = 0; l < LANES; l++) pft_mem[5][l*DATA_W +: DATA_W] = DATA_W'(l + 1);
    load_job(1);
    d0 = done_cnt;
    pulse_start(1);
    @(negedge clk);
    check("t1_adj_ren", adj_ren, 1);
    check("t1_adj_raddr", adj_raddr, 0);
    @(negedge clk);
    check("t1_pft_ren", pft_ren, 1);
    check("t1_pft_raddr", pft_raddr, 5);
    repeat (3) @(negedge clk);
    check("t1_busy_after", busy, 0);
    check("t1_dones", done_cnt - d0, 1);
    wait_idle(10);

    // Three samples with 2,1,3 neighbours, all rows +2.
    job_k[0] = 2; job_k[1] = 1; job_k[2] = 3;
    for (int i = 0; i < 6; i++) begin
      job_row[i] = 20 + i;
      set_row(20 + i, 2);
    end
    load_job(3);
    d0 = done_cnt;
    pulse_start(3);
    wait_idle(100);
    check("t2_dones", done_cnt - d0, 3);

    // Saturation: positive and negative clamp on lane 0.
    job_k[0] = 3; job_k[1] = 3;
    for (int i = 0; i < 6; i++) begin
      job_row[i] = 30 + i;
      pft_mem[30 + i][DATA_W-1:0] = (i < 3) ? 16'h7fff : 16'h8000;
    end
    load_job(2);
    d0 = done_cnt;
    pulse_start(2);
    wait_idle(100);
    check("sat_dones", done_cnt - d0, 2);

    // N=0: no reads, no done.
    d0 = done_cnt;
    pulse_start(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("n0_quiet", {busy, adj_ren, pft_ren}, 0);
    end
    check("n0_dones", done_cnt - d0, 0);

    // Second start mid-run is ignored.
    job_k[0] = 2; job_k[1] = 2; job_k[2] = 1;
    for (int i = 0; i < 5; i++) job_row[i] = $urandom_range(0, (1 << PW) - 1);
    load_job(3);
    d0 = done_cnt;
    pulse_start(3);
    repeat (3) @(posedge clk);
    #1 start_aggregation = 1'b1; n_sample = 13'd5;
    @(posedge clk); #1 start_aggregation = 1'b0;
    wait_idle(100);
    check("restart_ignored_dones", done_cnt - d0, 3);

    // Reset during the second neighbour's ACC cycle of the first sample.
    job_k[0] = 3; job_k[1] = 1;
    for (int i = 0; i < 4; i++) job_row[i] = $urandom_range(0, (1 << PW) - 1);
    load_job(2);
    d0 = done_cnt;
    pulse_start(2);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    exp_vec_q.delete();
    exp_cyc_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_out", out_data == '0, 1);
    repeat (10) @(negedge clk);
    check("rst_mid_dones", done_cnt - d0, 0);

    // Fresh job after reset must restart from adjacency address 0.
    job_k[0] = 2; job_k[1] = 2;
    for (int i = 0; i < 4; i++) job_row[i] = $urandom_range(0, (1 << PW) - 1);
    load_job(2);
    d0 = done_cnt;
    pulse_start(2);
    @(negedge clk);
    check("post_rst_addr0", adj_raddr, 0);
    wait_idle(100);
    check("post_rst_dones", done_cnt - d0, 2);

    // Randomized jobs, with occasional repeated neighbours.
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 6);
      p = 0;
      for (int s2 = 0; s2 < n; s2++) begin
        job_k[s2] = $urandom_range(1, 4);
        for (int j = 0; j < job_k[s2]; j++) begin
          if (p > 0 && $urandom_range(0, 3) == 0) job_row[p] = job_row[p-1];
          else job_row[p] = $urandom_range(0, (1 << PW) - 1);
          p++;
        end
      end
      load_job(n);
      d0 = done_cnt;
      pulse_start(n);
      wait_idle(200);
      check("rand_dones", done_cnt - d0, n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
